spi_prog_loader: RTL and testbench



---
 rtl/spi_loader_pkg.sv | 27 ++
 rtl/loader_fifo.sv | 63 ++++++
 rtl/spi_prog_loader.sv | 194 +++++++++++++++++++
 tb/tb_spi_prog_loader.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI program loader.
// SPI_LOADER_CHECKSUM_EN adds the CKSUM state used to verify a trailing checksum word.
package spi_loader_pkg;

`ifdef SPI_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        REQ   = 3'd1,
        RESP  = 3'd2,
        DONE  = 3'd3,
        RUN   = 3'd4,
        CKSUM = 3'd5
    } loader_state_e;
`else
    typedef enum logic [2:0] {
        LOAD = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        DONE = 3'd3,
        RUN  = 3'd4
    } loader_state_e;
`endif

    localparam logic [2:0]  PutFullData    = 3'h0;
    localparam logic [31:0] DefaultEndWord = 32'hFFFF_FFFF;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO buffering SPI words; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/spi_prog_loader.sv
// Streams SPI-received words into ICCM via TL-UL PutFullData, then releases core reset on en_i.
// Macro SPI_LOADER_CHECKSUM_EN: the word after END_WORD is a mod-2^32 checksum that must match.
module spi_prog_loader
    import spi_loader_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 4096,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] END_WORD   = DefaultEndWord
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] rx_word_i,
    input  logic                  rx_valid_i,
    input  logic                  en_i,
    output logic                  tl_a_valid_o,
    output logic [31:0]           tl_a_address_o,
    output logic [DATA_WIDTH-1:0] tl_a_data_o,
    output logic [3:0]            tl_a_mask_o,
    input  logic                  tl_a_ready_i,
    input  logic                  tl_d_valid_i,
    input  logic                  tl_d_error_i,
    output logic                  tl_d_ready_o,
    output logic                  system_rst_no,
    output logic                  load_done_o,
    output logic [15:0]           word_count_o,
    output logic                  overflow_o,
    output logic                  error_o
`ifdef SPI_LOADER_CHECKSUM_EN
    ,output logic [31:0]          checksum_o
`endif
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] MaxCount = 16'(MAX_WORDS);

    loader_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           addr_q, addr_d;
    logic [15:0]           count_q, count_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;
`ifdef SPI_LOADER_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
`endif

    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  unused_fifo_count;

    assign unused_fifo_count = ^fifo_count;

    // Once the core is running the SPI stream is no longer ours to buffer.
    assign fifo_push = rx_valid_i && (state_q != RUN);

    loader_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (fifo_push),
        .data_i (rx_word_i),
        .pop_i  (fifo_pop),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;
        ovf_d    = ovf_q | (fifo_push & fifo_full & ~fifo_pop);
        fifo_pop = 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        unique case (state_q)
            LOAD: begin
                if (!fifo_empty) begin
                    if (fifo_head == END_WORD) begin
                        fifo_pop = 1'b1;
`ifdef SPI_LOADER_CHECKSUM_EN
                        state_d  = CKSUM;
`else
                        state_d  = DONE;
`endif
                    end else if (count_q == MaxCount) begin
                        fifo_pop = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d = REQ;
                        data_d  = fifo_head;
                        addr_d  = BASE_ADDR + {14'b0, count_q, 2'b00};
                    end
                end
            end
            // The head stays in the FIFO until the A handshake so the stall is visible as backpressure.
            REQ: begin
                if (tl_a_ready_i) begin
                    fifo_pop = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (tl_d_valid_i) begin
                    if (count_q != MaxCount) begin
                        count_d = count_q + 1'b1;
                    end
                    if (tl_d_error_i) begin
                        err_d = 1'b1;
                    end
`ifdef SPI_LOADER_CHECKSUM_EN
                    sum_d = sum_q + data_q;
`endif
                    state_d = LOAD;
                end
            end
            DONE: begin
                if (en_i && !err_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
`ifdef SPI_LOADER_CHECKSUM_EN
            CKSUM: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_head != sum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SPI_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
`ifdef SPI_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        tl_a_valid_o   = (state_q == REQ);
        tl_a_mask_o    = (state_q == REQ) ? 4'hF : 4'h0;
        tl_a_address_o = addr_q;
        tl_a_data_o    = data_q;
        tl_d_ready_o   = (state_q == RESP);
        system_rst_no  = (state_q == RUN);
        load_done_o    = (state_q == DONE) || (state_q == RUN);
        word_count_o   = count_q;
        overflow_o     = ovf_q;
        error_o        = err_q;
`ifdef SPI_LOADER_CHECKSUM_EN
        checksum_o     = sum_q;
`endif
    end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed self-checking bench for spi_prog_loader, with a one-outstanding TL-UL crossbar model per instance.
// dut2 uses MAX_WORDS = 2 to exercise the capacity limit.
module tb_spi_prog_loader;

    localparam logic [31:0] EndWord = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic [31:0] rxWord;
    logic        rxValid;
    logic        en;
    logic        aReady;

    logic        aValid, dValid, dError, dReady, sysRstN, loadDone, overflow, error;
    logic [31:0] aAddr, aData;
    logic [3:0]  aMask;
    logic [15:0] wordCount;

    logic        aValid2, dValid2, dReady2, sysRstN2, loadDone2, overflow2, error2;
    logic [31:0] aAddr2, aData2;
    logic [3:0]  aMask2;
    logic [15:0] wordCount2;

`ifdef SPI_LOADER_CHECKSUM_EN
    logic [31:0] checksum, checksum2;
`endif

    logic        dHold;
    int          errAt;

    logic [31:0] logAddr [64];
    logic [31:0] logData [64];
    logic [3:0]  logMask [64];
    int          logN;
    logic [31:0] log2Addr [64];
    logic [31:0] log2Data [64];
    int          log2N;

    int          checkCount;
    int          passCount;

    spi_prog_loader dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_word_i     (rxWord),
        .rx_valid_i    (rxValid),
        .en_i          (en),
        .tl_a_valid_o  (aValid),
        .tl_a_address_o(aAddr),
        .tl_a_data_o   (aData),
        .tl_a_mask_o   (aMask),
        .tl_a_ready_i  (aReady),
        .tl_d_valid_i  (dValid),
        .tl_d_error_i  (dError),
        .tl_d_ready_o  (dReady),
        .system_rst_no (sysRstN),
        .load_done_o   (loadDone),
        .word_count_o  (wordCount),
        .overflow_o    (overflow),
        .error_o       (error)
`ifdef SPI_LOADER_CHECKSUM_EN
        ,.checksum_o   (checksum)
`endif
    );

    spi_prog_loader #(.MAX_WORDS(2)) dut2 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_word_i     (rxWord),
        .rx_valid_i    (rxValid),
        .en_i          (en),
        .tl_a_valid_o  (aValid2),
        .tl_a_address_o(aAddr2),
        .tl_a_data_o   (aData2),
        .tl_a_mask_o   (aMask2),
        .tl_a_ready_i  (1'b1),
        .tl_d_valid_i  (dValid2),
        .tl_d_error_i  (1'b0),
        .tl_d_ready_o  (dReady2),
        .system_rst_no (sysRstN2),
        .load_done_o   (loadDone2),
        .word_count_o  (wordCount2),
        .overflow_o    (overflow2),
        .error_o       (error2)
`ifdef SPI_LOADER_CHECKSUM_EN
        ,.checksum_o   (checksum2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Crossbar model: log each accepted A beat, answer on D the following cycle unless held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dValid <= 1'b0;
            dError <= 1'b0;
        end else begin
            dValid <= 1'b0;
            dError <= 1'b0;
            if (aValid && aReady && logN < 64) begin
                logAddr[logN] <= aAddr;
                logData[logN] <= aData;
                logMask[logN] <= aMask;
                dValid        <= !dHold;
                dError        <= (logN == errAt);
                logN          <= logN + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dValid2 <= 1'b0;
        end else begin
            dValid2 <= 1'b0;
            if (aValid2 && log2N < 64) begin
                log2Addr[log2N] <= aAddr2;
                log2Data[log2N] <= aData2;
                dValid2         <= 1'b1;
                log2N           <= log2N + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog");
    end

    task automatic resetDut();
        rst_n   = 1'b0;
        rxValid = 1'b0;
        rxWord  = '0;
        en      = 1'b0;
        aReady  = 1'b1;
        dHold   = 1'b0;
        errAt   = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        rxWord  = w;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
        @(negedge clk);
    endtask

    task automatic sendEnd(input logic [31:0] expSum);
        applyStimulus(EndWord);
`ifdef SPI_LOADER_CHECKSUM_EN
        applyStimulus(expSum);
`else
        if (expSum === 32'hxxxx_xxxx) $display("[TB] note: unknown checksum argument");
`endif
    endtask

    task automatic waitDone1();
        for (int i = 0; i < 300; i++) begin
            if (loadDone === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic waitDone2();
        for (int i = 0; i < 300; i++) begin
            if (loadDone2 === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rxValid = 1'b0;
        rxWord  = '0;
        en      = 1'b0;
        aReady  = 1'b1;
        dHold   = 1'b0;
        errAt   = -1;
        repeat (2) @(negedge clk);
        checkCount++;
        if ({aValid, aAddr, aData, aMask, dReady, sysRstN, loadDone, wordCount, overflow, error} !== '0) begin
            $display("[TB] FAIL reset_outputs: got valid=%0b addr=%h data=%h mask=%h dready=%0b srst=%0b done=%0b cnt=%0d ovf=%0b err=%0b, want all 0",
                     aValid, aAddr, aData, aMask, dReady, sysRstN, loadDone, wordCount, overflow, error);
        end else passCount++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        int start;
        logic [31:0] exp [3];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
        resetDut();
        start = logN;
        for (int k = 0; k < 3; k++) applyStimulus(exp[k]);
        sendEnd(32'h66);
        waitDone1();
        checkCount++;
        if (loadDone !== 1'b1) $display("[TB] FAIL basic_done: got %0b want 1", loadDone);
        else passCount++;
        checkCount++;
        if (logN - start != 3) $display("[TB] FAIL basic_write_count: got %0d want 3", logN - start);
        else passCount++;
        for (int k = 0; k < 3; k++) begin
            checkCount++;
            if ({logAddr[start+k], logData[start+k], logMask[start+k]} !== {32'(4 * k), exp[k], 4'hF})
                $display("[TB] FAIL basic_write%0d: got addr=%h data=%h mask=%h want addr=%h data=%h mask=f",
                         k, logAddr[start+k], logData[start+k], logMask[start+k], 32'(4 * k), exp[k]);
            else passCount++;
        end
        checkCount++;
        if (wordCount !== 16'd3) $display("[TB] FAIL basic_word_count: got %0d want 3", wordCount);
        else passCount++;
        repeat (3) @(negedge clk);
        checkCount++;
        if (sysRstN !== 1'b0) $display("[TB] FAIL basic_rst_held: got %0b want 0", sysRstN);
        else passCount++;
        en = 1'b1;
        @(negedge clk);
        checkCount++;
        if (sysRstN !== 1'b1) $display("[TB] FAIL basic_rst_release: got %0b want 1", sysRstN);
        else passCount++;
        start = logN;
        applyStimulus(32'h99);
        repeat (4) @(negedge clk);
        checkCount++;
        if (logN != start || aValid !== 1'b0)
            $display("[TB] FAIL run_ignores_rx: got writes=%0d avalid=%0b want 0 and 0", logN - start, aValid);
        else passCount++;
    endtask

    task automatic test_stall_overflow();
        int start;
        logic [31:0] w [6];
        resetDut();
        aReady = 1'b0;
        start  = logN;
        for (int i = 0; i < 6; i++) begin
            w[i]    = 32'hA000_0001 + 32'(i);
            rxWord  = w[i];
            rxValid = 1'b1;
            @(negedge clk);
        end
        rxValid = 1'b0;
        checkCount++;
        if (overflow !== 1'b1) $display("[TB] FAIL stall_overflow: got %0b want 1", overflow);
        else passCount++;
        for (int c = 0; c < 14; c++) begin
            checkCount++;
            if ({aValid, aAddr, aData, aMask} !== {1'b1, 32'h0, w[0], 4'hF})
                $display("[TB] FAIL stall_a_stable c%0d: got valid=%0b addr=%h data=%h mask=%h want 1/0/%h/f",
                         c, aValid, aAddr, aData, aMask, w[0]);
            else passCount++;
            @(negedge clk);
        end
        aReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (logN - start >= 4) break;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        checkCount++;
        if (logN - start != 4) $display("[TB] FAIL stall_buffered: got %0d writes want 4", logN - start);
        else passCount++;
        for (int k = 0; k < 4; k++) begin
            checkCount++;
            if ({logAddr[start+k], logData[start+k]} !== {32'(4 * k), w[k]})
                $display("[TB] FAIL stall_write%0d: got addr=%h data=%h want addr=%h data=%h",
                         k, logAddr[start+k], logData[start+k], 32'(4 * k), w[k]);
            else passCount++;
        end
        checkCount++;
        if (wordCount !== 16'd4) $display("[TB] FAIL stall_word_count: got %0d want 4", wordCount);
        else passCount++;
    endtask

    task automatic test_d_error();
        int start;
        resetDut();
        start = logN;
        errAt = start + 1;
        applyStimulus(32'h100);
        applyStimulus(32'h200);
        applyStimulus(32'h300);
        sendEnd(32'h600);
        waitDone1();
        checkCount++;
        if ({loadDone, error} !== 2'b11) $display("[TB] FAIL derr_flags: got done=%0b err=%0b want 1 1", loadDone, error);
        else passCount++;
        checkCount++;
        if (wordCount !== 16'd3) $display("[TB] FAIL derr_word_count: got %0d want 3", wordCount);
        else passCount++;
        en = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if (sysRstN !== 1'b0) $display("[TB] FAIL derr_rst_blocked: got %0b want 0", sysRstN);
        else passCount++;
        errAt = -1;
    endtask

    task automatic test_max_words();
        int start;
        resetDut();
        start = log2N;
        applyStimulus(32'h1);
        applyStimulus(32'h2);
        applyStimulus(32'h3);
        sendEnd(32'h3);
        waitDone2();
        checkCount++;
        if (loadDone2 !== 1'b1) $display("[TB] FAIL max_done: got %0b want 1", loadDone2);
        else passCount++;
        checkCount++;
        if (log2N - start != 2) $display("[TB] FAIL max_write_count: got %0d want 2", log2N - start);
        else passCount++;
        checkCount++;
        if ({log2Addr[start+1], log2Data[start+1]} !== {32'h4, 32'h2})
            $display("[TB] FAIL max_last_write: got addr=%h data=%h want 4 2", log2Addr[start+1], log2Data[start+1]);
        else passCount++;
        checkCount++;
        if ({error2, wordCount2} !== {1'b1, 16'd2})
            $display("[TB] FAIL max_err_count: got err=%0b cnt=%0d want 1 2", error2, wordCount2);
        else passCount++;
    endtask

    task automatic test_reset_midwrite();
        int start;
        resetDut();
        aReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rxWord  = 32'hB000_0000 + 32'(i);
            rxValid = 1'b1;
            @(negedge clk);
        end
        rxValid = 1'b0;
        dHold   = 1'b1;
        aReady  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (dReady === 1'b1) break;
            @(negedge clk);
        end
        checkCount++;
        if ({dReady, overflow} !== 2'b11)
            $display("[TB] FAIL midwrite_in_resp: got dready=%0b ovf=%0b want 1 1", dReady, overflow);
        else passCount++;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({dReady, aValid, overflow, error, wordCount} !== '0)
            $display("[TB] FAIL midwrite_async_clear: got dready=%0b avalid=%0b ovf=%0b err=%0b cnt=%0d want all 0",
                     dReady, aValid, overflow, error, wordCount);
        else passCount++;
        @(negedge clk);
        rst_n = 1'b1;
        dHold = 1'b0;
        @(negedge clk);
        start = logN;
        applyStimulus(32'h77);
        sendEnd(32'h77);
        waitDone1();
        checkCount++;
        if (logN - start != 1 || {logAddr[start], logData[start]} !== {32'h0, 32'h77})
            $display("[TB] FAIL midwrite_reload: got writes=%0d addr=%h data=%h want 1 0 77",
                     logN - start, logAddr[start], logData[start]);
        else passCount++;
        checkCount++;
        if ({loadDone, overflow, error, wordCount} !== {1'b1, 1'b0, 1'b0, 16'd1})
            $display("[TB] FAIL midwrite_flags: got done=%0b ovf=%0b err=%0b cnt=%0d want 1 0 0 1",
                     loadDone, overflow, error, wordCount);
        else passCount++;
    endtask

`ifdef SPI_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        resetDut();
        applyStimulus(32'd1);
        applyStimulus(32'd2);
        applyStimulus(32'd3);
        applyStimulus(EndWord);
        applyStimulus(32'd6);
        waitDone1();
        checkCount++;
        if ({loadDone, error, checksum} !== {1'b1, 1'b0, 32'd6})
            $display("[TB] FAIL cksum_good: got done=%0b err=%0b sum=%0d want 1 0 6", loadDone, error, checksum);
        else passCount++;
        en = 1'b1;
        @(negedge clk);
        checkCount++;
        if (sysRstN !== 1'b1) $display("[TB] FAIL cksum_good_run: got %0b want 1", sysRstN);
        else passCount++;
        resetDut();
        applyStimulus(32'd1);
        applyStimulus(32'd2);
        applyStimulus(32'd3);
        applyStimulus(EndWord);
        applyStimulus(32'd7);
        waitDone1();
        en = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({loadDone, error, sysRstN} !== 3'b110)
            $display("[TB] FAIL cksum_bad: got done=%0b err=%0b srst=%0b want 1 1 0", loadDone, error, sysRstN);
        else passCount++;
    endtask
`endif

    initial begin
        checkCount = 0;
        passCount  = 0;
        logN       = 0;
        log2N      = 0;
        test_reset();
        test_basic_load();
        test_stall_overflow();
        test_d_error();
        test_max_words();
        test_reset_midwrite();
`ifdef SPI_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
